ls_fu: RTL

- Load/store functional unit; consumes issued LDUR/STUR operations from the reservation stations over the rs_interface signal set.
- Produces results on the fu_interface signal set for ROB write-back and broadcast.
- Owns a private word-addressed data memory.
- One operation in flight at a time; fixed latency of LS_DELAY cycles; flushable on mispredict.

---
 rtl/ls_fu_pkg.sv | 34 +++
 rtl/ls_fu_dmem.sv | 22 ++
 rtl/ls_fu.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ls_fu_pkg.sv
// rtl/ls_fu_pkg.sv - shared load/store FU types, sizes and FSM state encoding
package ls_fu_pkg;

  localparam int GPR_SIZE     = 64;
  localparam int ROB_IDX_SIZE = 6;
  localparam int LS_DELAY_DEF = 3;

  typedef enum logic [2:0] {
    FU_OP_NOP  = 3'd0,
    FU_OP_ADD  = 3'd1,
    FU_OP_LDUR = 3'd2,
    FU_OP_STUR = 3'd3
  } fu_op_t;

  typedef enum logic [1:0] {
    LS_OP_NONE  = 2'd0,
    LS_OP_LOAD  = 2'd1,
    LS_OP_STORE = 2'd2
  } ls_op_t;

  typedef logic [1:0] ls_state_t;
  localparam ls_state_t LS_IDLE = 2'd0;
  localparam ls_state_t LS_BUSY = 2'd1;
  localparam ls_state_t LS_DONE = 2'd2;

  function automatic ls_op_t ls_op_of(fu_op_t op);
    case (op)
      FU_OP_LDUR: return LS_OP_LOAD;
      FU_OP_STUR: return LS_OP_STORE;
      default:    return LS_OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ls_fu_dmem.sv
// rtl/ls_fu_dmem.sv - single-port synchronous data RAM with registered read
module ls_dmem #(
  parameter int MEM_WORDS = 256,
  parameter int IDX_W     = $clog2(MEM_WORDS),
  parameter int DATA_W    = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  // Read-first: rdata reflects the word as it was before a same-edge write.
  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
    rdata <= mem_q[idx];
  end

endmodule

// File: rtl/ls_fu.sv
// rtl/ls_fu.sv - load/store FU with private RAM; LS_STORE_FAST_EN enables single-cycle stores
module ls_fu
  import ls_fu_pkg::*;
#(
  parameter int LS_DELAY     = LS_DELAY_DEF,
  parameter int MEM_WORDS    = 256,
  parameter int MEM_IDX_SIZE = $clog2(MEM_WORDS)
) (
  input  logic                    clk_in,
  input  logic                    rst_N_in,
  input  logic                    flush_in,
  input  logic                    start_in,
  input  fu_op_t                  fu_op_in,
  input  logic [GPR_SIZE-1:0]     val_a_in,
  input  logic [GPR_SIZE-1:0]     val_b_in,
  input  logic [ROB_IDX_SIZE-1:0] dst_rob_index_in,
  output logic                    ready_out,
  output logic                    done_out,
  output logic [ROB_IDX_SIZE-1:0] dst_rob_index_out,
  output logic [GPR_SIZE-1:0]     value_out,
  output fu_op_t                  fu_op_out
);

  localparam int CNT_W = $clog2(LS_DELAY) + 1;

  ls_state_t               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  fu_op_t                  op_q, op_d, op_out_q, op_out_d;
  logic [MEM_IDX_SIZE-1:0] idx_q, idx_d;
  logic [GPR_SIZE-1:0]     data_q, data_d, value_q, value_d;
  logic [ROB_IDX_SIZE-1:0] rob_q, rob_d, rob_out_q, rob_out_d;

  logic                    accept, access, fast_st, mem_we;
  logic [MEM_IDX_SIZE-1:0] in_idx, mem_idx;
  logic [GPR_SIZE-1:0]     mem_wdata, mem_rdata;
  logic                    unused_addr_bits;

  assign in_idx           = val_a_in[MEM_IDX_SIZE+2:3];
  assign unused_addr_bits = ^{val_a_in[GPR_SIZE-1:MEM_IDX_SIZE+3], val_a_in[2:0]};

  assign ready_out = (state_q != LS_BUSY);
  assign accept    = start_in && ready_out && !flush_in;
  assign access    = (state_q == LS_BUSY) && (cnt_q == CNT_W'(1)) && !flush_in;

`ifdef LS_STORE_FAST_EN
  assign fast_st = accept && (ls_op_of(fu_op_in) == LS_OP_STORE);
`else
  assign fast_st = 1'b0;
`endif

  assign mem_we    = rst_N_in && (fast_st || (access && (ls_op_of(op_q) == LS_OP_STORE)));
  assign mem_idx   = fast_st ? in_idx : idx_q;
  assign mem_wdata = fast_st ? val_b_in : data_q;

  ls_dmem #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (MEM_IDX_SIZE),
    .DATA_W    (GPR_SIZE)
  ) u_dmem (
    .clk   (clk_in),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign done_out          = (state_q == LS_DONE);
  assign dst_rob_index_out = rob_out_q;
  assign fu_op_out         = op_out_q;
  // Load data only exists in the RAM read register during DONE; it is frozen into value_q then.
  assign value_out = (done_out && ls_op_of(op_out_q) == LS_OP_LOAD) ? mem_rdata : value_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    idx_d     = idx_q;
    data_d    = data_q;
    rob_d     = rob_q;
    rob_out_d = rob_out_q;
    op_out_d  = op_out_q;
    value_d   = value_q;
    if (state_q == LS_DONE) value_d = value_out;

    case (state_q)
      LS_BUSY: begin
        if (flush_in) begin
          state_d = LS_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d   = LS_DONE;
          rob_out_d = rob_q;
          op_out_d  = op_q;
          value_d   = (ls_op_of(op_q) == LS_OP_STORE) ? data_q : '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = LS_IDLE;
        if (accept) begin
          state_d = LS_BUSY;
          cnt_d   = CNT_W'(LS_DELAY - 1);
          op_d    = fu_op_in;
          idx_d   = in_idx;
          data_d  = val_b_in;
          rob_d   = dst_rob_index_in;
          if (fast_st) begin
            state_d   = LS_DONE;
            rob_out_d = dst_rob_index_in;
            op_out_d  = fu_op_in;
            value_d   = val_b_in;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      state_q   <= LS_IDLE;
      cnt_q     <= '0;
      op_q      <= FU_OP_NOP;
      idx_q     <= '0;
      data_q    <= '0;
      rob_q     <= '0;
      rob_out_q <= '0;
      op_out_q  <= FU_OP_NOP;
      value_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      rob_q     <= rob_d;
      rob_out_q <= rob_out_d;
      op_out_q  <= op_out_d;
      value_q   <= value_d;
    end
  end

endmodule
